// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU-to-internal-target bus bridge:
// FSM state encoding, 16-bit lane selectors and the value returned
// when a read has no owner.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_REQ  = 2'd2,
        ST_DONE = 2'd3
    } bus_state_e;

    // Which 16-bit half of the 32-bit target word a CPU transfer uses (cpu_a[1]).
    localparam logic        LANE_LO   = 1'b0;
    localparam logic        LANE_HI   = 1'b1;
    localparam logic [15:0] ZERO_HALF = 16'h0000;

    // Read data returned when no target answers (no decode hit or timeout).
    localparam logic [15:0] DEAD_DATA = 16'hFFFF;

    // 32-bit byte-lane mask from the active-low CPU byte enables and word half.
    function automatic logic [3:0] lane_mask(input logic bhe_n, input logic ble_n, input logic a1);
        return {~bhe_n & a1, ~ble_n & a1, ~bhe_n & ~a1, ~ble_n & ~a1};
    endfunction

    // Place a 16-bit CPU word into its half of the 32-bit target word.
    function automatic logic [31:0] place_half(input logic [15:0] d, input logic a1);
        logic [31:0] w;
        if (a1 == LANE_HI) begin
            w = {d, ZERO_HALF};
        end else begin
            w = {ZERO_HALF, d};
        end
        return w;
    endfunction

    // Pick the 16-bit half of a 32-bit target word that the CPU addressed.
    function automatic logic [15:0] pick_half(input logic [31:0] d, input logic a1);
        logic [15:0] h;
        if (a1 == LANE_HI) begin
            h = d[31:16];
        end else begin
            h = d[15:0];
        end
        return h;
    endfunction

endpackage

// File: rtl/cpu_bus_decode.sv
// Combinational address decoder: maps a CPU byte address to a one-hot
// target select. Target i owns the address when (addr & MASK_i) == BASE_i;
// the lowest matching index wins, and IO-space cycles always go to target 0.
module cpu_bus_decode
    import cpu_bus_pkg::*;
#(
    parameter int                          ADDR_W   = 24,
    parameter int                          NUM_TGT  = 4,
    parameter logic [NUM_TGT*ADDR_W-1:0]   TGT_BASE = {24'hFF0000, 24'hF00000, 24'h0F0000, 24'h000000},
    parameter logic [NUM_TGT*ADDR_W-1:0]   TGT_MASK = {24'hFF0000, 24'hF00000, 24'hFF0000, 24'h000000}
)(
    input  logic [ADDR_W-1:0]  i_addr,
    input  logic               i_io,
    output logic [NUM_TGT-1:0] o_sel,
    output logic               o_hit
);

    logic [NUM_TGT-1:0] w_match;
    logic [NUM_TGT-1:0] w_lowest;

    // Compare the address against every region independently.
    always_comb begin
        w_match = '0;
        for (int i = 0; i < NUM_TGT; i++) begin
            w_match[i] = ((i_addr & TGT_MASK[i*ADDR_W +: ADDR_W]) == TGT_BASE[i*ADDR_W +: ADDR_W]);
        end
    end

    // Isolate the lowest set bit so overlapping regions resolve to the lowest index.
    assign w_lowest = w_match & (~w_match + NUM_TGT'(1));

    // IO space bypasses the region table; any select means a hit.
    always_comb begin
        if (i_io) begin
            o_sel = NUM_TGT'(1);
        end else begin
            o_sel = w_lowest;
        end
        o_hit = |o_sel;
    end

endmodule

// File: rtl/cpu_bus_bridge.sv
// 16-bit CPU bus to one-hot internal target bridge.
// IDLE samples ADS#, ADDR decodes and launches the request, REQ holds the
// request until the selected target acks, DONE drives READY# low for one clock.
// Compile option CPU_BUS_TIMEOUT_EN adds a REQ-state watchdog that abandons
// the cycle after TIMEOUT_CYCLES clocks and pulses bus_timeout.
module cpu_bus_bridge
    import cpu_bus_pkg::*;
#(
    parameter int                          ADDR_W         = 24,
    parameter int                          NUM_TGT        = 4,
    parameter logic [NUM_TGT*ADDR_W-1:0]   TGT_BASE       = {24'hFF0000, 24'hF00000, 24'h0F0000, 24'h000000},
    parameter logic [NUM_TGT*ADDR_W-1:0]   TGT_MASK       = {24'hFF0000, 24'hF00000, 24'hFF0000, 24'h000000},
    parameter int                          TIMEOUT_CYCLES = 255
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_W-1:1]       cpu_a,
    inout  wire  [15:0]             cpu_d,
    input  logic                    cpu_ads_n,
    input  logic                    cpu_bhe_n,
    input  logic                    cpu_ble_n,
    input  logic                    cpu_mio,
    input  logic                    cpu_wr,
    output logic                    cpu_ready_n,
    output logic [NUM_TGT-1:0]      tgt_req,
    output logic                    tgt_wr,
    output logic                    tgt_io,
    output logic [ADDR_W-3:0]       tgt_addr,
    output logic [31:0]             tgt_wdata,
    output logic [3:0]              tgt_mask,
    input  logic [NUM_TGT-1:0]      tgt_ack,
    input  logic [NUM_TGT*32-1:0]   tgt_rdata,
    output logic                    bus_timeout,
    output logic [1:0]              state
);

    // Registered state and datapath
    bus_state_e          r_state;
    logic [ADDR_W-1:1]   r_a;
    logic                r_io;
    logic                r_wr;
    logic [3:0]          r_mask;
    logic [NUM_TGT-1:0]  r_req;
    logic [31:0]         r_wdata;
    logic [15:0]         r_rdata;
    logic                r_drive;
    logic                r_ready_n;
    logic                r_timeout;

    // Next-state values
    bus_state_e          w_state_nxt;
    logic [ADDR_W-1:1]   w_a_nxt;
    logic                w_io_nxt;
    logic                w_wr_nxt;
    logic [3:0]          w_mask_nxt;
    logic [NUM_TGT-1:0]  w_req_nxt;
    logic [31:0]         w_wdata_nxt;
    logic [15:0]         w_rdata_nxt;
    logic                w_drive_nxt;
    logic                w_ready_n_nxt;
    logic                w_timeout_nxt;

    // Decode and completion helpers
    logic [ADDR_W-1:0]   w_byte_addr;
    logic [NUM_TGT-1:0]  w_dec_sel;
    logic                w_dec_hit;
    logic                w_ack;
    logic [31:0]         w_sel_rdata;
    logic                w_tmo_hit;

    assign w_byte_addr = {r_a, 1'b0};

    cpu_bus_decode #(
        .ADDR_W   (ADDR_W),
        .NUM_TGT  (NUM_TGT),
        .TGT_BASE (TGT_BASE),
        .TGT_MASK (TGT_MASK)
    ) u_decode (
        .i_addr (w_byte_addr),
        .i_io   (r_io),
        .o_sel  (w_dec_sel),
        .o_hit  (w_dec_hit)
    );

    // Only the target that holds the request may complete the cycle.
    assign w_ack = |(tgt_ack & r_req);

    // One-hot read-data mux driven by the held request vector.
    always_comb begin
        w_sel_rdata = 32'h0000_0000;
        for (int i = 0; i < NUM_TGT; i++) begin
            w_sel_rdata = w_sel_rdata | (tgt_rdata[i*32 +: 32] & {32{r_req[i]}});
        end
    end

`ifdef CPU_BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_tmo_cnt;

    // Count unanswered REQ clocks; cleared whenever the FSM is anywhere else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == ST_REQ) && !w_ack && !w_tmo_hit) begin
            r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
        end else begin
            r_tmo_cnt <= '0;
        end
    end

    assign w_tmo_hit = (r_state == ST_REQ) && (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // No watchdog: REQ waits for the ack indefinitely and the limit has no hardware behind it.
    logic [31:0] w_unused_tmo;
    assign w_unused_tmo = 32'(TIMEOUT_CYCLES);
    assign w_tmo_hit    = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-datapath logic; every field holds unless a state updates it.
    always_comb begin
        w_state_nxt   = r_state;
        w_a_nxt       = r_a;
        w_io_nxt      = r_io;
        w_wr_nxt      = r_wr;
        w_mask_nxt    = r_mask;
        w_req_nxt     = r_req;
        w_wdata_nxt   = r_wdata;
        w_rdata_nxt   = r_rdata;
        w_drive_nxt   = 1'b0;
        w_ready_n_nxt = 1'b1;
        w_timeout_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!cpu_ads_n) begin
                    w_a_nxt     = cpu_a;
                    w_io_nxt    = ~cpu_mio;
                    w_wr_nxt    = cpu_wr;
                    w_mask_nxt  = lane_mask(cpu_bhe_n, cpu_ble_n, cpu_a[1]);
                    w_state_nxt = ST_ADDR;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (w_dec_hit) begin
                    w_req_nxt   = w_dec_sel;
                    if (r_wr) begin
                        w_wdata_nxt = place_half(cpu_d, r_a[1]);
                    end else begin
                        w_wdata_nxt = 32'h0000_0000;
                    end
                    w_state_nxt = ST_REQ;
                end else begin
                    // Unclaimed address: finish at once with the dead pattern.
                    w_rdata_nxt   = DEAD_DATA;
                    w_drive_nxt   = ~r_wr;
                    w_ready_n_nxt = 1'b0;
                    w_state_nxt   = ST_DONE;
                end
            end
            ST_REQ: begin
                if (w_ack) begin
                    w_req_nxt     = '0;
                    w_rdata_nxt   = pick_half(w_sel_rdata, r_a[1]);
                    w_drive_nxt   = ~r_wr;
                    w_ready_n_nxt = 1'b0;
                    w_state_nxt   = ST_DONE;
                end else if (w_tmo_hit) begin
                    w_req_nxt     = '0;
                    w_rdata_nxt   = DEAD_DATA;
                    w_drive_nxt   = ~r_wr;
                    w_ready_n_nxt = 1'b0;
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = ST_DONE;
                end else begin
                    w_state_nxt   = ST_REQ;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a       <= '0;
            r_io      <= 1'b0;
            r_wr      <= 1'b0;
            r_mask    <= 4'h0;
            r_req     <= '0;
            r_wdata   <= 32'h0000_0000;
            r_rdata   <= 16'h0000;
            r_drive   <= 1'b0;
            r_ready_n <= 1'b1;
            r_timeout <= 1'b0;
        end else begin
            r_a       <= w_a_nxt;
            r_io      <= w_io_nxt;
            r_wr      <= w_wr_nxt;
            r_mask    <= w_mask_nxt;
            r_req     <= w_req_nxt;
            r_wdata   <= w_wdata_nxt;
            r_rdata   <= w_rdata_nxt;
            r_drive   <= w_drive_nxt;
            r_ready_n <= w_ready_n_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign cpu_d       = r_drive ? r_rdata : 16'hzzzz;
    assign cpu_ready_n = r_ready_n;
    assign tgt_req     = r_req;
    assign tgt_wr      = r_wr;
    assign tgt_io      = r_io;
    assign tgt_addr    = r_a[ADDR_W-1:2];
    assign tgt_wdata   = r_wdata;
    assign tgt_mask    = r_mask;
    assign bus_timeout = r_timeout;
    assign state       = r_state;

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Self-checking bench for cpu_bus_bridge: directed scenarios followed by
// randomized cycles, all checked against a region-table reference model.
module tb_cpu_bus_bridge;

    localparam int AW  = 24;
    localparam int NT  = 4;
    localparam int TMO = 8;
`ifdef CPU_BUS_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    // Region map: 00xxxx->0, 0Fxxxx->1, Fxxxxx->2 (FFxxxx shadowed by 2), Exxxxx unclaimed.
    localparam logic [NT*AW-1:0] P_BASE = {24'hFF0000, 24'hF00000, 24'h0F0000, 24'h000000};
    localparam logic [NT*AW-1:0] P_MASK = {24'hFF0000, 24'hF00000, 24'hFF0000, 24'hFF0000};

    logic [23:0] m_base [NT] = '{24'h000000, 24'h0F0000, 24'hF00000, 24'hFF0000};
    logic [23:0] m_mask [NT] = '{24'hFF0000, 24'hFF0000, 24'hF00000, 24'hFF0000};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:1] cpu_a = '0;
    tri0  [15:0]   cpu_d;
    logic [15:0]   tb_dout = 16'h0000;
    logic          tb_drive = 1'b0;
    logic          cpu_ads_n = 1'b1, cpu_bhe_n = 1'b1, cpu_ble_n = 1'b1, cpu_mio = 1'b1, cpu_wr = 1'b0;
    logic          cpu_ready_n;
    logic [NT-1:0] tgt_req;
    logic          tgt_wr, tgt_io;
    logic [AW-3:0] tgt_addr;
    logic [31:0]   tgt_wdata;
    logic [3:0]    tgt_mask;
    logic [NT-1:0] tgt_ack = '0;
    logic [NT*32-1:0] tgt_rdata = '0;
    logic          bus_timeout;
    logic [1:0]    state;

    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt = 0;

    assign cpu_d = tb_drive ? tb_dout : 16'hzzzz;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    cpu_bus_bridge #(
        .ADDR_W(AW), .NUM_TGT(NT), .TGT_BASE(P_BASE), .TGT_MASK(P_MASK), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .cpu_a(cpu_a), .cpu_d(cpu_d),
        .cpu_ads_n(cpu_ads_n), .cpu_bhe_n(cpu_bhe_n), .cpu_ble_n(cpu_ble_n),
        .cpu_mio(cpu_mio), .cpu_wr(cpu_wr), .cpu_ready_n(cpu_ready_n),
        .tgt_req(tgt_req), .tgt_wr(tgt_wr), .tgt_io(tgt_io), .tgt_addr(tgt_addr),
        .tgt_wdata(tgt_wdata), .tgt_mask(tgt_mask), .tgt_ack(tgt_ack), .tgt_rdata(tgt_rdata),
        .bus_timeout(bus_timeout), .state(state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Which target owns a byte address; -1 when nobody does.
    function automatic int model_target(input logic [23:0] addr, input bit io);
        if (io) return 0;
        for (int i = 0; i < NT; i++) begin
            if ((addr & m_mask[i]) == m_base[i]) return i;
        end
        return -1;
    endfunction

    // Run one CPU cycle. ack_n: REQ clock on which the owner acks (0 = never).
    // stray: another target that acks on the non-ack clocks (-1 = none).
    task automatic bus_cycle(input string tag, input logic [23:0] addr, input bit wr, input bit mio,
                             input bit bhe_n, input bit ble_n, input logic [15:0] wd,
                             input int ack_n, input int stray, input logic [31:0] rd);
        int          t;
        int          lane;
        int          ads_edge;
        bit          done;
        logic [3:0]  emask;
        logic [31:0] ewd;
        logic [15:0] erd;
        t     = model_target(addr, !mio);
        lane  = addr[1] ? 2 : 0;
        emask = 4'h0;
        if (!ble_n) emask[lane] = 1'b1;
        if (!bhe_n) emask[lane+1] = 1'b1;
        ewd   = wr ? (32'(wd) << (16 * lane / 2)) : 32'h0;
        erd   = (t < 0) ? 16'hFFFF : (addr[1] ? rd[31:16] : rd[15:0]);
        for (int i = 0; i < NT; i++) tgt_rdata[i*32 +: 32] = $urandom;
        if (t >= 0) tgt_rdata[t*32 +: 32] = rd;

        @(negedge clk);
        cpu_a = addr[23:1]; cpu_wr = wr; cpu_mio = mio; cpu_bhe_n = bhe_n; cpu_ble_n = ble_n;
        cpu_ads_n = 1'b0;
        tb_dout = wd; tb_drive = wr;
        ads_edge = edge_cnt + 1;
        @(negedge clk);
        cpu_ads_n = 1'b1;
        chk({tag, "_addr_state"}, 32'(state), 32'd1);
        chk({tag, "_addr_ready"}, 32'(cpu_ready_n), 32'd1);
        chk({tag, "_addr_noreq"}, 32'(tgt_req), 32'd0);
        @(negedge clk);
        if (t < 0) begin
            tb_drive = 1'b0;
            chk({tag, "_miss_noreq"}, 32'(tgt_req), 32'd0);
            chk({tag, "_miss_ready"}, 32'(cpu_ready_n), 32'd0);
            chk({tag, "_miss_lat"}, 32'(edge_cnt - ads_edge + 1), 32'd2);
            if (!wr) chk({tag, "_miss_data"}, 32'(cpu_d), 32'(erd));
        end else begin
            tb_drive = 1'b0;
            done = 1'b0;
            for (int n = 1; n <= 64 && !done; n++) begin
                chk({tag, "_req"}, 32'(tgt_req), 32'(1 << t));
                chk({tag, "_taddr"}, 32'(tgt_addr), 32'(addr[23:2]));
                chk({tag, "_tmask"}, 32'(tgt_mask), 32'(emask));
                chk({tag, "_twr"}, 32'(tgt_wr), 32'(wr));
                chk({tag, "_tio"}, 32'(tgt_io), 32'(!mio));
                if (wr) chk({tag, "_wdata"}, tgt_wdata, ewd);
                if (n == ack_n) tgt_ack[t] = 1'b1;
                else if (stray >= 0 && stray != t) tgt_ack[stray] = 1'b1;
                @(negedge clk);
                tgt_ack = '0;
                if (n == ack_n || (TMO_EN && ack_n == 0 && n == TMO)) begin
                    done = 1'b1;
                    chk({tag, "_done_ready"}, 32'(cpu_ready_n), 32'd0);
                    chk({tag, "_done_state"}, 32'(state), 32'd3);
                    chk({tag, "_done_noreq"}, 32'(tgt_req), 32'd0);
                    chk({tag, "_done_tmo"}, 32'(bus_timeout), 32'(n != ack_n));
                    if (n == ack_n) chk({tag, "_lat"}, 32'(edge_cnt - ads_edge + 1), 32'(2 + ack_n));
                    if (!wr) chk({tag, "_rdata"}, 32'(cpu_d), (n == ack_n) ? 32'(erd) : 32'h0000FFFF);
                end else begin
                    chk({tag, "_wait_ready"}, 32'(cpu_ready_n), 32'd1);
                    chk({tag, "_wait_tmo"}, 32'(bus_timeout), 32'd0);
                end
            end
            if (!done) chk({tag, "_bound"}, 32'd0, 32'd1);
        end
        @(negedge clk);
        chk({tag, "_end_ready"}, 32'(cpu_ready_n), 32'd1);
        chk({tag, "_end_state"}, 32'(state), 32'd0);
        chk({tag, "_end_tmo"}, 32'(bus_timeout), 32'd0);
        chk({tag, "_end_float"}, 32'(cpu_d), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [23:0] bases [5];
        logic [23:0] a;
        bases = '{24'h000000, 24'h0F0000, 24'hF00000, 24'hFF0000, 24'hE00000};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ready", 32'(cpu_ready_n), 32'd1);
        chk("rst_req", 32'(tgt_req), 32'd0);
        chk("rst_tmo", 32'(bus_timeout), 32'd0);
        chk("rst_wdata", tgt_wdata, 32'd0);
        chk("rst_float", 32'(cpu_d), 32'd0);
        rst = 1'b0;

        // Directed scenarios
        bus_cycle("rd_t1", 24'h0F0002, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1, -1, 32'h12345678);
        bus_cycle("wr_t0", 24'h000004, 1'b1, 1'b1, 1'b1, 1'b0, 16'hBEEF, 5, -1, 32'h0);
        bus_cycle("rd_miss", 24'hE00000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1, -1, 32'h0);
        bus_cycle("stray", 24'h000100, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 3, 2, 32'hCAFEF00D);
        bus_cycle("io_t0", 24'hE00006, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 2, 1, 32'hA5A55A5A);
        bus_cycle("shadow", 24'hFF0010, 1'b1, 1'b1, 1'b0, 1'b1, 16'h1357, 1, 3, 32'h0);
`ifdef CPU_BUS_TIMEOUT_EN
        bus_cycle("timeout", 24'h000020, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 0, -1, 32'h11112222);
`else
        bus_cycle("longwait", 24'h000020, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 20, -1, 32'h11112222);
`endif

        // Reset while waiting in REQ, then a late ack
        @(negedge clk);
        cpu_a = 23'(24'h000010 >> 1); cpu_wr = 1'b0; cpu_mio = 1'b1; cpu_ads_n = 1'b0;
        cpu_bhe_n = 1'b0; cpu_ble_n = 1'b0;
        @(negedge clk);
        cpu_ads_n = 1'b1;
        @(negedge clk);
        chk("rreq_state", 32'(state), 32'd2);
        rst = 1'b1;
        #1;
        chk("rreq_rst_state", 32'(state), 32'd0);
        chk("rreq_rst_ready", 32'(cpu_ready_n), 32'd1);
        chk("rreq_rst_req", 32'(tgt_req), 32'd0);
        chk("rreq_rst_mask", 32'(tgt_mask), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tgt_ack[0] = 1'b1;
        @(negedge clk);
        tgt_ack = '0;
        for (int k = 0; k < 4; k++) begin
            chk("rreq_post_ready", 32'(cpu_ready_n), 32'd1);
            chk("rreq_post_state", 32'(state), 32'd0);
            chk("rreq_post_float", 32'(cpu_d), 32'd0);
            @(negedge clk);
        end

        // Randomized cycles
        for (int k = 0; k < 30; k++) begin
            a = bases[$urandom_range(0, 4)] | (24'($urandom_range(0, 65535)) & 24'h00FFFE);
            bus_cycle("rand", a, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
                      $urandom_range(1, 4), int'($urandom_range(0, 4)) - 1, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
